// File: rtl/uart_frame_loader_if.sv
// Byte-stream intake and word-store port of the UART program loader.
// The master side is the loader; the slave side is UART RX plus memory.
interface uart_frame_loader_if;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic        mem_wen;
    logic [31:0] mem_wa;
    logic [31:0] mem_wd;
    logic [2:0]  mem_funct3;

    modport master (
        input  rx_data,
        input  rx_valid,
        output rx_ready,
        output mem_wen,
        output mem_wa,
        output mem_wd,
        output mem_funct3
    );

    modport slave (
        output rx_data,
        output rx_valid,
        input  rx_ready,
        input  mem_wen,
        input  mem_wa,
        input  mem_wd,
        input  mem_funct3
    );
endinterface

// File: rtl/uart_frame_loader.sv
// Streams a framed UART image (sync, 16-bit length, payload, XOR checksum)
// into memory as little-endian word stores while holding the CPU in reset.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | waiting for SYNC_BYTE, other bytes discarded
// LEN_LO  | capturing low byte of payload length
// LEN_HI  | capturing high byte of length, range-checking it
// PAYLOAD | packing bytes into words, issuing word stores
// CHECK   | comparing the received checksum with the XOR accumulator
module uart_frame_loader #(
    parameter int unsigned MAX_BYTES      = 2048,
    parameter logic [31:0] BASE_ADDR      = 32'h0000_0000,
    parameter logic [7:0]  SYNC_BYTE      = 8'hA5,
    parameter int unsigned TIMEOUT_CYCLES = 240000
) (
    input  logic                clk,
    input  logic                reset,
    uart_frame_loader_if.master bus,
    output logic                cpu_reset_n,
    output logic                busy,
    output logic                done,
    output logic                err,
    output logic [1:0]          err_code
);

    localparam int unsigned WORDS   = MAX_BYTES / 4;
    localparam int unsigned IDX_W   = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam int unsigned TO_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES);
    localparam logic [15:0] MAX_LEN = 16'(MAX_BYTES);

    localparam logic [1:0] ERR_NONE    = 2'd0;
    localparam logic [1:0] ERR_LENGTH  = 2'd1;
    localparam logic [1:0] ERR_CHKSUM  = 2'd2;
    localparam logic [1:0] ERR_TIMEOUT = 2'd3;

    typedef enum logic [2:0] {
        IDLE,
        LEN_LO,
        LEN_HI,
        PAYLOAD,
        CHECK
    } state_t;

    state_t            state;
    logic [15:0]       len;
    logic [15:0]       count;
    logic [7:0]        acc;
    logic [1:0]        lane;
    logic [23:0]       lanes;
    logic [IDX_W-1:0]  word_idx;
    logic [TO_W-1:0]   tcnt;

    logic              accept;
    logic [7:0]        d;
    logic [15:0]       count_nxt;
    logic [15:0]       len_nxt;
    logic              last_byte;
    logic [31:0]       word_addr;
    logic [31:0]       word_nxt;

    assign accept    = bus.rx_valid & bus.rx_ready;
    assign d         = bus.rx_data;
    assign count_nxt = count + 16'd1;
    assign len_nxt   = {d, len[7:0]};
    assign last_byte = (count_nxt == len);
    assign word_addr = BASE_ADDR + {{(30 - IDX_W){1'b0}}, word_idx, 2'b00};

    // A final byte in lanes 0-2 closes a partial word with zeroed upper lanes.
    always_comb begin
        word_nxt = {d, lanes};
        case (lane)
            2'd0:    word_nxt = {24'h0, d};
            2'd1:    word_nxt = {16'h0, d, lanes[7:0]};
            2'd2:    word_nxt = {8'h0, d, lanes[15:0]};
            default: word_nxt = {d, lanes};
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state          <= IDLE;
            len            <= '0;
            count          <= '0;
            acc            <= '0;
            lane           <= '0;
            lanes          <= '0;
            word_idx       <= '0;
            tcnt           <= '0;
            bus.rx_ready   <= 1'b0;
            bus.mem_wen    <= 1'b0;
            bus.mem_wa     <= '0;
            bus.mem_wd     <= '0;
            bus.mem_funct3 <= 3'b010;
            cpu_reset_n    <= 1'b0;
            busy           <= 1'b0;
            done           <= 1'b0;
            err            <= 1'b0;
            err_code       <= ERR_NONE;
        end else begin
            bus.mem_funct3 <= 3'b010;
            bus.mem_wen    <= 1'b0;
            done           <= 1'b0;

            if (!bus.rx_ready) begin
                // first edge out of reset: boot release, intake opens
                bus.rx_ready <= 1'b1;
                cpu_reset_n  <= 1'b1;
            end else if (state != IDLE && tcnt == TO_LAST) begin
                // timeout takes priority; a byte arriving now is dropped
                state    <= IDLE;
                busy     <= 1'b0;
                err      <= 1'b1;
                err_code <= ERR_TIMEOUT;
                tcnt     <= '0;
            end else begin
                if (state != IDLE) begin
                    tcnt <= accept ? '0 : tcnt + TO_W'(1);
                end

                if (accept) begin
                    case (state)
                        IDLE: begin
                            if (d == SYNC_BYTE) begin
                                state       <= LEN_LO;
                                err         <= 1'b0;
                                err_code    <= ERR_NONE;
                                cpu_reset_n <= 1'b0;
                                busy        <= 1'b1;
                                acc         <= '0;
                                lane        <= '0;
                                word_idx    <= '0;
                                count       <= '0;
                                tcnt        <= '0;
                            end
                        end

                        LEN_LO: begin
                            len[7:0] <= d;
                            state    <= LEN_HI;
                        end

                        LEN_HI: begin
                            len <= len_nxt;
                            if (len_nxt == 16'd0 || len_nxt > MAX_LEN) begin
                                state    <= IDLE;
                                busy     <= 1'b0;
                                err      <= 1'b1;
                                err_code <= ERR_LENGTH;
                            end else begin
                                state <= PAYLOAD;
                            end
                        end

                        PAYLOAD: begin
                            acc   <= acc ^ d;
                            count <= count_nxt;
                            lane  <= lane + 2'd1;
                            if (lane != 2'd3) begin
                                lanes[8*lane +: 8] <= d;
                            end
                            if (lane == 2'd3 || last_byte) begin
                                bus.mem_wen <= 1'b1;
                                bus.mem_wa  <= word_addr;
                                bus.mem_wd  <= word_nxt;
                                word_idx    <= word_idx + 1'b1;
                            end
                            if (last_byte) begin
                                state <= CHECK;
                            end
                        end

                        CHECK: begin
                            state <= IDLE;
                            busy  <= 1'b0;
                            if (d == acc) begin
                                done        <= 1'b1;
                                cpu_reset_n <= 1'b1;
                            end else begin
                                err      <= 1'b1;
                                err_code <= ERR_CHKSUM;
                            end
                        end

                        default: state <= IDLE;
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_uart_frame_loader.sv
// Directed bench for uart_frame_loader: frame table plus hand-written
// sequences for write timing, back-to-back frames, timeout and reset abort.
module tb_uart_frame_loader;

    localparam int unsigned MAX_BYTES = 64;
    localparam int unsigned TMO       = 20;

    logic       clk = 1'b0;
    logic       reset;
    logic       cpu_reset_n, busy, done, err;
    logic [1:0] err_code;

    uart_frame_loader_if bus ();

    uart_frame_loader #(
        .MAX_BYTES     (MAX_BYTES),
        .BASE_ADDR     (32'h0000_0100),
        .SYNC_BYTE     (8'hA5),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .bus        (bus),
        .cpu_reset_n(cpu_reset_n),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .err_code   (err_code)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [31:0] wa_q[$];
    logic [31:0] wd_q[$];
    int          done_cnt = 0;

    always @(negedge clk) begin
        if (bus.mem_wen) begin
            wa_q.push_back(bus.mem_wa);
            wd_q.push_back(bus.mem_wd);
        end
        if (done) done_cnt++;
    end

    typedef struct packed {
        logic [95:0] bytes;
        int          n;
        int          nw;
        logic [31:0] wa0;
        logic [31:0] wd0;
        logic [31:0] wa1;
        logic [31:0] wd1;
        logic        done;
        logic        err;
        logic [1:0]  code;
        logic        cpu;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic send(input logic [7:0] b);
        bus.rx_data  = b;
        bus.rx_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.rx_valid = 1'b0;
    endtask

    task automatic idle(input int k);
        repeat (k) @(posedge clk);
        #1;
    endtask

    task automatic clear_mon();
        wa_q.delete();
        wd_q.delete();
        done_cnt = 0;
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        clear_mon();
        for (int i = 0; i < v.n; i++) send(v.bytes[8*(v.n-1-i) +: 8]);
        idle(2);
        chk({tag, ".nwrites"}, 32'(wa_q.size()), 32'(v.nw));
        if (v.nw > 0 && wa_q.size() > 0) begin
            chk({tag, ".wa0"}, wa_q[0], v.wa0);
            chk({tag, ".wd0"}, wd_q[0], v.wd0);
        end
        if (v.nw > 1 && wa_q.size() > 1) begin
            chk({tag, ".wa1"}, wa_q[1], v.wa1);
            chk({tag, ".wd1"}, wd_q[1], v.wd1);
        end
        chk({tag, ".done"},  32'(done_cnt), 32'(v.done));
        chk({tag, ".err"},   32'(err), 32'(v.err));
        chk({tag, ".code"},  32'(err_code), 32'(v.code));
        chk({tag, ".cpu"},   32'(cpu_reset_n), 32'(v.cpu));
        chk({tag, ".busy"},  32'(busy), 32'h0);
    endtask

    initial begin
        vecs[0] = '{96'({8'hA5, 8'h08, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88, 8'h88}),
                    12, 2, 32'h100, 32'h44332211, 32'h104, 32'h88776655, 1'b1, 1'b0, 2'd0, 1'b1};
        vecs[1] = '{96'({8'hA5, 8'h05, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h01}),
                    9, 2, 32'h100, 32'h04030201, 32'h104, 32'h00000005, 1'b1, 1'b0, 2'd0, 1'b1};
        vecs[2] = '{96'({8'hA5, 8'h08, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88, 8'h00}),
                    12, 2, 32'h100, 32'h44332211, 32'h104, 32'h88776655, 1'b0, 1'b1, 2'd2, 1'b0};
        vecs[3] = '{96'({8'hA5, 8'h03, 8'h00, 8'hAA, 8'hBB, 8'hA5, 8'hB4}),
                    7, 1, 32'h100, 32'h00A5BBAA, 32'h0, 32'h0, 1'b1, 1'b0, 2'd0, 1'b1};
        vecs[4] = '{96'({8'h12, 8'h34, 8'hA5, 8'h00, 8'h00}),
                    5, 0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b1, 2'd1, 1'b0};
        vecs[5] = '{96'({8'hA5, 8'h44, 8'h00}),
                    3, 0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b1, 2'd1, 1'b0};
        vecs[6] = '{96'({8'hA5, 8'h01, 8'h00, 8'hA5, 8'hA5}),
                    5, 1, 32'h100, 32'h000000A5, 32'h0, 32'h0, 1'b1, 1'b0, 2'd0, 1'b1};
        vecs[7] = '{96'({8'hA5, 8'h02, 8'h00, 8'hDE, 8'hAD, 8'h73}),
                    6, 1, 32'h100, 32'h0000ADDE, 32'h0, 32'h0, 1'b1, 1'b0, 2'd0, 1'b1};

        reset        = 1'b1;
        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        chk("rst.rx_ready", 32'(bus.rx_ready), 32'h0);
        chk("rst.mem_wen",  32'(bus.mem_wen), 32'h0);
        chk("rst.mem_wa",   bus.mem_wa, 32'h0);
        chk("rst.mem_wd",   bus.mem_wd, 32'h0);
        chk("rst.funct3",   32'(bus.mem_funct3), 32'h2);
        chk("rst.cpu",      32'(cpu_reset_n), 32'h0);
        chk("rst.busy",     32'(busy), 32'h0);
        chk("rst.done",     32'(done), 32'h0);
        chk("rst.err",      32'(err), 32'h0);
        chk("rst.code",     32'(err_code), 32'h0);
        reset = 1'b0;
        idle(1);
        chk("boot.rx_ready", 32'(bus.rx_ready), 32'h1);
        chk("boot.cpu",      32'(cpu_reset_n), 32'h1);

        for (int i = 0; i < 8; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

        // write timing, hold of address/data, back-to-back frames
        clear_mon();
        send(8'hA5);
        chk("sync.busy", 32'(busy), 32'h1);
        chk("sync.cpu",  32'(cpu_reset_n), 32'h0);
        send(8'h04); send(8'h00);
        send(8'h01); send(8'h02); send(8'h03);
        chk("wt.wen_early", 32'(bus.mem_wen), 32'h0);
        send(8'h04);
        chk("wt.wen",  32'(bus.mem_wen), 32'h1);
        chk("wt.wa",   bus.mem_wa, 32'h100);
        chk("wt.wd",   bus.mem_wd, 32'h04030201);
        idle(1);
        chk("wt.wen_drop", 32'(bus.mem_wen), 32'h0);
        chk("wt.wa_hold",  bus.mem_wa, 32'h100);
        chk("wt.wd_hold",  bus.mem_wd, 32'h04030201);
        send(8'h04);
        chk("b2b.done1", 32'(done), 32'h1);
        chk("b2b.cpu1",  32'(cpu_reset_n), 32'h1);
        chk("b2b.busy1", 32'(busy), 32'h0);
        send(8'hA5);
        chk("b2b.done_pulse", 32'(done), 32'h0);
        chk("b2b.cpu0",  32'(cpu_reset_n), 32'h0);
        chk("b2b.busy",  32'(busy), 32'h1);
        send(8'h01); send(8'h00); send(8'h7E); send(8'h7E);
        chk("b2b.done2", 32'(done), 32'h1);
        chk("b2b.cpu2",  32'(cpu_reset_n), 32'h1);
        idle(1);
        chk("b2b.nwrites", 32'(wa_q.size()), 32'h2);
        if (wd_q.size() > 1) chk("b2b.wd1", wd_q[1], 32'h0000007E);

        // timeout: stall of TMO idle cycles after payload byte 3
        clear_mon();
        send(8'hA5); send(8'h08); send(8'h00);
        send(8'h11); send(8'h22); send(8'h33);
        idle(TMO);
        chk("tmo.err_before", 32'(err), 32'h0);
        chk("tmo.busy_before", 32'(busy), 32'h1);
        send(8'hA5);
        chk("tmo.err",  32'(err), 32'h1);
        chk("tmo.code", 32'(err_code), 32'h3);
        chk("tmo.busy_dropped", 32'(busy), 32'h0);
        chk("tmo.cpu",  32'(cpu_reset_n), 32'h0);
        idle(2);
        chk("tmo.nwrites", 32'(wa_q.size()), 32'h0);

        // stall one cycle short of the timeout completes normally
        clear_mon();
        send(8'hA5); send(8'h08); send(8'h00);
        send(8'h11); send(8'h22); send(8'h33);
        idle(TMO - 1);
        send(8'h44); send(8'h55); send(8'h66); send(8'h77); send(8'h88); send(8'h88);
        idle(2);
        chk("near.done", 32'(done_cnt), 32'h1);
        chk("near.err",  32'(err), 32'h0);
        chk("near.cpu",  32'(cpu_reset_n), 32'h1);
        chk("near.nwrites", 32'(wa_q.size()), 32'h2);

        // reset mid-payload aborts the frame
        clear_mon();
        send(8'hA5); send(8'h08); send(8'h00);
        send(8'h11); send(8'h22); send(8'h33); send(8'h44); send(8'h55);
        chk("abort.pre_writes", 32'(wa_q.size()), 32'h1);
        clear_mon();
        reset = 1'b1;
        #1;
        chk("abort.rx_ready", 32'(bus.rx_ready), 32'h0);
        chk("abort.wen",  32'(bus.mem_wen), 32'h0);
        chk("abort.wa",   bus.mem_wa, 32'h0);
        chk("abort.wd",   bus.mem_wd, 32'h0);
        chk("abort.busy", 32'(busy), 32'h0);
        chk("abort.cpu",  32'(cpu_reset_n), 32'h0);
        chk("abort.err",  32'(err), 32'h0);
        idle(1);
        reset = 1'b0;
        send(8'h66); send(8'h77); send(8'h88); send(8'h88);
        idle(3);
        chk("abort.nwrites", 32'(wa_q.size()), 32'h0);
        run_vec(vecs[0], "after_abort");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_frame_loader.md
# uart_frame_loader

- Parametrised program loader between the UART RX byte stream and the unified memory write port.
- Parses a framed image: sync byte, 16-bit length, payload, XOR checksum.
- Packs payload bytes little-endian into 32-bit word writes starting at a base address, and holds the CPU in reset for the whole load.
- Supersedes fixed 512-byte, fill-then-copy loading: any length up to `MAX_BYTES`, streaming writes, integrity check and inter-byte timeout.

## Interface
Parameters:
- `MAX_BYTES`, 2048: largest accepted payload. Must be a multiple of 4 and ≤ 65535.
- `BASE_ADDR`, 32'h0000_0000: byte address of payload byte 0. Word aligned.
- `SYNC_BYTE`, 8'hA5: frame start marker.
- `TIMEOUT_CYCLES`, 240000: maximum idle cycles between bytes inside a frame.

Ports (one clock; reset is asynchronous and active-high):
- `clk` in 1: system clock.
- `reset` in 1: asynchronous, active-high reset.
- `rx_data` in 8: received byte.
- `rx_valid` in 1: `rx_data` valid.
- `rx_ready` out 1: loader can take a byte.
- `mem_wen` out 1: memory write strobe, one cycle per word.
- `mem_wa` out 32: write byte address.
- `mem_wd` out 32: write data.
- `mem_funct3` out 3: always 3'b010 (word store).
- `cpu_reset_n` out 1: active-low CPU reset.
- `busy` out 1: frame in progress.
- `done` out 1: one-cycle pulse on a successful load.
- `err` out 1: sticky error flag.
- `err_code` out 2: error cause. 0 none, 1 length, 2 checksum, 3 timeout.

## Operation
- **Byte transfer:** a byte is accepted on a rising edge with `rx_valid & rx_ready`. `rx_ready` is registered: 0 in reset, 1 from the first edge after reset deassertion, then constantly 1.
- **States:** `IDLE`, `LEN_LO`, `LEN_HI`, `PAYLOAD`, `CHECK`.
- **IDLE:**
  - A byte equal to `SYNC_BYTE` goes to `LEN_LO`. It also clears `err`/`err_code`, drives `cpu_reset_n`=0, sets `busy`=1, and clears the XOR accumulator, byte lane and word index.
  - Any other byte is discarded.
- **LEN_LO / LEN_HI:** capture the length L, low byte first.
  - After `LEN_HI`: if L==0 or L>`MAX_BYTES`, return to `IDLE` with `err`=1, code 1.
  - Otherwise go to `PAYLOAD`.
- **PAYLOAD:**
  - Each byte is XORed into the accumulator and placed in lane (count mod 4). Lane 0 is bits 7:0.
  - After lane 3, the word is written at `BASE_ADDR` + 4·word_idx and word_idx increments.
  - If the final byte (count==L) lands in lanes 0–2, the partial word is written immediately with the unused upper lanes zero.
  - Then go to `CHECK`.
- **CHECK:** the received byte is compared with the accumulator.
  - Match: `done` pulse, `cpu_reset_n`=1, `busy`=0, go to `IDLE`.
  - Mismatch: `err`=1, code 2, `cpu_reset_n` stays 0, `busy`=0, go to `IDLE`.
- **Timeout:** in any state other than `IDLE`, a counter resets on each accepted byte and increments otherwise. On reaching `TIMEOUT_CYCLES`: `err`=1, code 3, go to `IDLE`, `cpu_reset_n` stays 0.
- **After an error:** the CPU remains in reset until a later frame completes successfully. Memory may hold a partial image; there is no rollback.
- **Arithmetic widths:**
  - Byte count is 16 bits.
  - word_idx is clog2(`MAX_BYTES`/4) bits.
  - Address = `BASE_ADDR` + {word_idx, 2'b00}, computed in 32 bits.
  - Timeout counter is clog2(`TIMEOUT_CYCLES`+1) bits and saturates.
- **SYNC_BYTE inside a frame:** inside length, payload or checksum it is ordinary data, never a restart.

## Timing
- **Reset values:**
  - `rx_ready`, `mem_wen`, `mem_wa`, `mem_wd`, `busy`, `done`, `err`, `err_code` are 0.
  - `mem_funct3` is 3'b010.
  - `cpu_reset_n` is 0. It rises on the first edge after reset deassertion (boot release); the state is `IDLE`.
- **Registered outputs:** all outputs are registered.
  - The byte completing a word (or the last payload byte), accepted at edge N, gives `mem_wen`=1 with valid `mem_wa`/`mem_wd` for exactly the cycle after edge N.
  - `mem_wa`/`mem_wd` hold their value after the write; only `mem_wen` drops.
- **Sync:** accepted at edge N, `cpu_reset_n`=0 and `busy`=1 are visible after edge N.
- **Checksum byte:** accepted at edge N, `done`/`cpu_reset_n`=1 (or `err`) are visible after edge N. `done` is high for one cycle.
- **Throughput:** one byte per cycle is sustained; the write path never stalls intake.
- **Back-to-back frames:** a sync byte on the cycle after the checksum is accepted and starts the next frame. `done` and the new `cpu_reset_n`=0 may then occur on consecutive cycles.
- **Reset mid-frame:** asserting `reset` mid-frame aborts immediately. Outputs go to reset values, and no further writes are issued for the aborted frame.
- **Timeout boundary:** fires exactly `TIMEOUT_CYCLES` cycles after the last accepted byte, error visible on the following cycle. A byte accepted on the firing cycle is dropped.

## Test plan
- **8-byte frame:** A5 08 00 11 22 33 44 55 66 77 88, cks=88 → writes 0x44332211 @0x0 and 0x88776655 @0x4, then `done`, `cpu_reset_n`=1, `err`=0.
- **5-byte payload:** 01 02 03 04 05 → writes 0x04030201 @0x0 and 0x00000005 @0x4, checksum 01 accepted.
- **Bad checksum:** 8-byte frame with cks=00 → both writes issued, `err`=1, `err_code`=2, `cpu_reset_n` stays 0. A following good frame clears `err` and releases the CPU.
- **Length errors:** L=0, and L=`MAX_BYTES`+4 → `err_code`=1, no `mem_wen`, `IDLE` reached; bytes before a sync are discarded.
- **Timeout:** stall after payload byte 3 for `TIMEOUT_CYCLES` cycles → `err_code`=3. Stall of `TIMEOUT_CYCLES`−1 cycles → frame completes normally.
- **Reset mid-payload:** assert `reset` during payload → all outputs return to reset values, no further writes. With `BASE_ADDR`=0x100, a full frame afterwards writes starting @0x100.
